nios_debug_cmd_bridge: RTL and testbench

NIOS_DEBUG_CMD_BRIDGE -- requirements
Module: nios_debug_cmd_bridge

---
 rtl/nios_debug_pkg.sv | 23 ++
 rtl/nios_debug_cmd_fifo.sv | 59 +++++
 rtl/nios_debug_cmd_bridge.sv | 165 ++++++++++++++++
 tb/tb_nios_debug_cmd_bridge.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_debug_pkg.sv
// Shared types and constants for the Nios debug command bridge.
// Holds the output FSM encoding, default sizes and a clog2 helper.
package nios_debug_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_e;

   localparam int DEF_DATA_W      = 38;
   localparam int DEF_IR_W        = 2;
   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FIFO_DEPTH  = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/nios_debug_cmd_fifo.sv
// Command queue: power-of-two ring buffer with wrap-around pointers.
// A push into a full queue is accepted only when a pop happens that cycle.
module nios_debug_cmd_fifo
   import nios_debug_pkg::*;
#(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [W-1:0]          wdata_i,
   output logic [W-1:0]          rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [clog2(DEPTH):0] level_o
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign level_o = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   // Pointers and occupancy; simultaneous push/pop leaves the count alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/nios_debug_cmd_bridge.sv
// JTAG update-DR to system-clock command bridge for the Nios debug unit.
// Syncs the update toggle, queues {channel, data} and presents one at a time.
module nios_debug_cmd_bridge
   import nios_debug_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int IR_W        = DEF_IR_W,
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       udr_tgl,
   input  logic [DATA_W-1:0]          sr,
   input  logic [IR_W-1:0]            ir_in,
   input  logic                       cmd_ready,
   input  logic                       clr_sticky,
   output logic [DATA_W-1:0]          jdo,
   output logic                       cmd_valid,
   output logic [NUM_CH-1:0]          take_action,
   output logic [NUM_CH-1:0]          take_no_action,
   output logic [clog2(FIFO_DEPTH):0] fifo_level,
   output logic                       ovf_sticky,
   output logic                       badch_sticky
);

   localparam int EW = IR_W + DATA_W;
   localparam int MW = clog2(SYNC_STAGES + 2);
   localparam logic [MW-1:0] ARM_N = MW'(SYNC_STAGES + 1);
   localparam logic [IR_W:0] NCH   = NUM_CH[IR_W:0];

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [MW-1:0]          arm_q;
   logic                   upd;
   logic                   evt_q;
   logic [IR_W-1:0]        ir_s_q;
   logic [DATA_W-1:0]      sr_s_q;
   logic                   bad;
   logic                   push;
   logic                   pop;
   logic                   hs;
   logic                   full;
   logic                   empty;
   logic [EW-1:0]          rdata;
   state_e                 state_q;
   state_e                 state_d;
   logic [IR_W-1:0]        ch_q;
   logic [DATA_W-1:0]      jdo_q;
   logic [NUM_CH-1:0]      ch_oh;
   logic [NUM_CH-1:0]      act_q;
   logic [NUM_CH-1:0]      nact_q;
   logic                   ovf_q;
   logic                   bad_q;

   assign upd  = (arm_q == ARM_N) && (sync_q[SYNC_STAGES-1] != prev_q);
   assign bad  = evt_q && ({1'b0, ir_s_q} >= NCH);
   assign push = evt_q && !bad;

   // Toggle synchronizer; previous value always tracks, events are armed late.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         arm_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], udr_tgl};
         prev_q <= sync_q[SYNC_STAGES-1];
         if (arm_q != ARM_N) arm_q <= arm_q + 1'b1;
      end
   end

   // Capture the JTAG-side words in the cycle the update event fires.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         evt_q  <= 1'b0;
         ir_s_q <= '0;
         sr_s_q <= '0;
      end else begin
         evt_q <= upd;
         if (upd) begin
            ir_s_q <= ir_in;
            sr_s_q <= sr;
         end
      end
   end

   nios_debug_cmd_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({ir_s_q, sr_s_q}),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );

   // Output FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Output FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (!empty)    state_d = ST_VALID;
         ST_VALID: if (cmd_ready) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Output FSM decode: pop in IDLE, present and handshake in VALID.
   always_comb begin
      pop       = 1'b0;
      hs        = 1'b0;
      cmd_valid = 1'b0;
      unique case (state_q)
         ST_IDLE:  pop = !empty;
         ST_VALID: begin
            cmd_valid = 1'b1;
            hs        = cmd_ready;
         end
         default:  pop = 1'b0;
      endcase
   end

   // Channel number of the presented command as a one-hot vector.
   always_comb begin
      ch_oh = '0;
      for (int i = 0; i < NUM_CH; i++) ch_oh[i] = (ch_q == IR_W'(i));
   end

   // Presented command register, action pulses and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch_q   <= '0;
         jdo_q  <= '0;
         act_q  <= '0;
         nact_q <= '0;
         ovf_q  <= 1'b0;
         bad_q  <= 1'b0;
      end else begin
         if (pop) {ch_q, jdo_q} <= rdata;
         act_q  <= (hs && jdo_q[DATA_W-1])  ? ch_oh : '0;
         nact_q <= (hs && !jdo_q[DATA_W-1]) ? ch_oh : '0;
         ovf_q  <= (push && full && !pop) || (ovf_q && !clr_sticky);
         bad_q  <= bad || (bad_q && !clr_sticky);
      end
   end

   assign jdo            = jdo_q;
   assign take_action    = act_q;
   assign take_no_action = nact_q;
   assign ovf_sticky     = ovf_q;
   assign badch_sticky   = bad_q;

endmodule

// File: tb/tb_nios_debug_cmd_bridge.sv
// Bench for nios_debug_cmd_bridge: queue-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_nios_debug_cmd_bridge;

   localparam int DW = 38;
   localparam int IW = 2;
   localparam int NC = 3;
   localparam int QD = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          udr_tgl;
   logic [DW-1:0] sr;
   logic [IW-1:0] ir_in;
   logic          cmd_ready;
   logic          clr_sticky;
   logic [DW-1:0] jdo;
   logic          cmd_valid;
   logic [NC-1:0] take_action;
   logic [NC-1:0] take_no_action;
   logic [2:0]    fifo_level;
   logic          ovf_sticky;
   logic          badch_sticky;

   int checks = 0;
   int errors = 0;

   nios_debug_cmd_bridge #(
      .DATA_W      (DW),
      .IR_W        (IW),
      .NUM_CH      (NC),
      .SYNC_STAGES (2),
      .FIFO_DEPTH  (QD)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .udr_tgl        (udr_tgl),
      .sr             (sr),
      .ir_in          (ir_in),
      .cmd_ready      (cmd_ready),
      .clr_sticky     (clr_sticky),
      .jdo            (jdo),
      .cmd_valid      (cmd_valid),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .fifo_level     (fifo_level),
      .ovf_sticky     (ovf_sticky),
      .badch_sticky   (badch_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: updates become queue entries 3 edges after the
   // toggle is first seen; one entry is presented at a time.
   logic [IW+DW-1:0] mq[$];
   int               pdue[$];
   logic [IW+DW-1:0] pdat[$];
   int               cyc;
   bit               first;
   logic             prev_u;
   bit               m_valid;
   logic [DW-1:0]    m_jdo;
   logic [IW-1:0]    m_ch;
   logic [NC-1:0]    m_act;
   logic [NC-1:0]    m_nact;
   bit               m_ovf;
   bit               m_bad;

   always @(posedge clk or negedge reset_n) begin : model
      bit hs;
      bit pop;
      bit ovf_set;
      bit bad_set;
      logic [IW+DW-1:0] e;
      if (!reset_n) begin
         mq.delete();
         pdue.delete();
         pdat.delete();
         cyc     = 0;
         first   = 1;
         prev_u  = 1'b0;
         m_valid = 0;
         m_jdo   = '0;
         m_ch    = '0;
         m_act   = '0;
         m_nact  = '0;
         m_ovf   = 0;
         m_bad   = 0;
      end else begin
         cyc++;
         hs      = m_valid && cmd_ready;
         pop     = !m_valid && (mq.size() > 0);
         ovf_set = 0;
         bad_set = 0;
         m_act   = '0;
         m_nact  = '0;
         if (hs) begin
            if (m_jdo[DW-1]) m_act[m_ch] = 1'b1;
            else             m_nact[m_ch] = 1'b1;
            m_valid = 0;
         end else if (pop) begin
            e = mq.pop_front();
            m_ch    = e[IW+DW-1:DW];
            m_jdo   = e[DW-1:0];
            m_valid = 1;
         end
         while (pdue.size() > 0 && pdue[0] == cyc) begin
            void'(pdue.pop_front());
            e = pdat.pop_front();
            if (int'(e[IW+DW-1:DW]) >= NC) bad_set = 1;
            else if (mq.size() == QD)      ovf_set = 1;
            else                           mq.push_back(e);
         end
         if (first) begin
            prev_u = udr_tgl;
            first  = 0;
         end else if (udr_tgl != prev_u) begin
            prev_u = udr_tgl;
            pdue.push_back(cyc + 3);
            pdat.push_back({ir_in, sr});
         end
         m_ovf = ovf_set || (m_ovf && !clr_sticky);
         m_bad = bad_set || (m_bad && !clr_sticky);
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      chk("cmd_valid", cmd_valid, m_valid);
      chk("jdo", jdo, m_jdo);
      chk("take_action", take_action, m_act);
      chk("take_no_action", take_no_action, m_nact);
      chk("fifo_level", fifo_level, mq.size());
      chk("ovf_sticky", ovf_sticky, m_ovf);
      chk("badch_sticky", badch_sticky, m_bad);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tog(input logic [IW-1:0] ir, input logic [DW-1:0] d);
      step(1);
      ir_in   = ir;
      sr      = d;
      udr_tgl = ~udr_tgl;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!cmd_valid && n < 30) begin
         step(1);
         n++;
      end
   endtask

   int               n;
   logic [NC-1:0]    acc_a;
   logic [NC-1:0]    acc_n;
   int               pulses;
   logic [DW-1:0]    d0;
   logic [DW-1:0]    held;

   initial begin
      reset_n    = 1'b0;
      udr_tgl    = 1'b0;
      sr         = '0;
      ir_in      = '0;
      cmd_ready  = 1'b0;
      clr_sticky = 1'b0;
      #2;
      chk("rst_valid", cmd_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_jdo", jdo, 0);
      step(3);
      reset_n = 1'b1;
      step(6);

      // Single action command, ready already high.
      cmd_ready = 1'b1;
      tog(2'd2, 38'h20_0000_1234);
      n = 0;
      while (n < 20) begin
         step(1);
         n++;
         if (cmd_valid) break;
      end
      chk("lat", n, 5);
      chk("t1_jdo", jdo, 38'h20_0000_1234);
      step(1);
      chk("t1_act", take_action, 3'b100);
      chk("t1_nact", take_no_action, 3'b000);
      step(1);
      chk("t1_act_off", take_action, 3'b000);

      // No-action command on channel 0.
      tog(2'd0, 38'h01_2345_6789);
      acc_a = '0;
      acc_n = '0;
      repeat (12) begin
         step(1);
         acc_a |= take_action;
         acc_n |= take_no_action;
      end
      chk("t2_nact", acc_n, 3'b001);
      chk("t2_act", acc_a, 3'b000);

      // Overflow: six updates with ready low, one is presented, four queue.
      cmd_ready = 1'b0;
      d0 = 38'h20_0000_0010;
      for (int i = 0; i < 6; i++) begin
         tog(IW'(i % NC), DW'(i + 16) | (i[0] ? '0 : 38'h20_0000_0000));
         step(5);
      end
      step(4);
      chk("t3_level", fifo_level, 4);
      chk("t3_ovf", ovf_sticky, 1);
      chk("t3_valid", cmd_valid, 1);
      chk("t3_jdo", jdo, d0);
      held = jdo;
      step(10);
      chk("t3_hold", jdo, held);
      clr_sticky = 1'b1;
      step(1);
      clr_sticky = 1'b0;
      chk("t3_clr", ovf_sticky, 0);
      cmd_ready = 1'b1;
      pulses = 0;
      repeat (20) begin
         step(1);
         pulses += $countones(take_action) + $countones(take_no_action);
      end
      chk("t3_pulses", pulses, 5);
      chk("t3_empty", fifo_level, 0);

      // Bad channel, with clear held on the cycle the flag is set.
      tog(2'd3, 38'h3f_ffff_ffff);
      step(3);
      clr_sticky = 1'b1;
      step(1);
      clr_sticky = 1'b0;
      chk("t4_bad", badch_sticky, 1);
      step(4);
      chk("t4_level", fifo_level, 0);
      chk("t4_valid", cmd_valid, 0);
      clr_sticky = 1'b1;
      step(1);
      clr_sticky = 1'b0;
      chk("t4_clr", badch_sticky, 0);

      // Reset with the toggle held high: no spurious command.
      reset_n = 1'b0;
      udr_tgl = 1'b1;
      step(3);
      reset_n = 1'b1;
      step(10);
      chk("t5_valid", cmd_valid, 0);
      chk("t5_level", fifo_level, 0);

      // Reset while a command is presented and a second one is queued.
      cmd_ready = 1'b0;
      tog(2'd1, 38'h20_0000_00aa);
      step(5);
      tog(2'd2, 38'h20_0000_00bb);
      wait_valid(n);
      chk("t6_valid", cmd_valid, 1);
      step(6);
      cmd_ready = 1'b1;
      reset_n   = 1'b0;
      #1;
      chk("t6_rvalid", cmd_valid, 0);
      chk("t6_rjdo", jdo, 0);
      chk("t6_rlevel", fifo_level, 0);
      acc_a = '0;
      acc_n = '0;
      step(2);
      reset_n = 1'b1;
      repeat (10) begin
         step(1);
         acc_a |= take_action;
         acc_n |= take_no_action;
      end
      chk("t6_nopulse", {acc_a, acc_n}, 0);

      // Bridge still works after reset.
      tog(2'd1, 38'h20_0000_0055);
      acc_a = '0;
      repeat (12) begin
         step(1);
         acc_a |= take_action;
      end
      chk("t7_act", acc_a, 3'b010);

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
